// File: rtl/nes_inv_pipe.sv
// nes_inv_pipe: per-beat transform (pass / invert / XOR mask / mute) followed
// by an elastic valid/ready register pipeline, with a delivered-beat counter.
module nes_inv_pipe #(
  parameter int DW     = 3,
  parameter int STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [DW-1:0] cfg_mask,
  input  logic [1:0]    mode,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_dat,
  output logic [15:0]   beat_cnt
);

  logic [DW-1:0]     mask_q;
  logic [DW-1:0]     in_xf;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] open;
  logic [DW-1:0]     d [STAGES];

  // Mask register; all ones out of reset so mode 2 behaves like the legacy inverter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= '1;
    else if (cfg_we) mask_q <= cfg_mask;
  end

  // Transform applied at stage-0 entry; mode and mask are bound here, per beat.
  always_comb begin
    in_xf = '0;
    unique case (mode)
      2'd0:    in_xf = in_dat;
      2'd1:    in_xf = ~in_dat;
      2'd2:    in_xf = in_dat ^ mask_q;
      default: in_xf = '0;
    endcase
  end

  // Ready chain: stage i is open if any stage from i downstream is empty or the
  // sink accepts. Depends only on v and out_rdy, never on in_vld.
  always_comb begin
    open = '0;
    for (int i = 0; i < STAGES; i++) begin
      open[i] = out_rdy;
      for (int j = i; j < STAGES; j++) begin
        if (!v[j]) open[i] = 1'b1;
      end
    end
  end

  // Pipeline registers; data only moves with a valid beat so idle stages hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= '0;
    end else begin
      if (open[0]) begin
        v[0] <= in_vld;
        if (in_vld) d[0] <= in_xf;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (open[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) d[i] <= d[i-1];
        end
      end
    end
  end

  // Delivered-beat counter, wraps modulo 2^16.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat_cnt <= '0;
    else if (out_vld && out_rdy) beat_cnt <= beat_cnt + 16'd1;
  end

  assign in_rdy  = open[0];
  assign out_vld = v[STAGES-1];
  assign out_dat = d[STAGES-1];

endmodule

// File: tb/tb_nes_inv_pipe.sv
// Directed bench for nes_inv_pipe: a DW=3 and a DW=8 instance, both STAGES=2.
module tb_nes_inv_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DW=3 instance
  logic       cfg_we3, in_vld3, in_rdy3, out_vld3, out_rdy3;
  logic [2:0] cfg_mask3, in_dat3, out_dat3;
  logic [1:0] mode3;
  logic [15:0] cnt3;

  // DW=8 instance
  logic       cfg_we8, in_vld8, in_rdy8, out_vld8, out_rdy8;
  logic [7:0] cfg_mask8, in_dat8, out_dat8;
  logic [1:0] mode8;
  logic [15:0] cnt8;

  int errors = 0;
  int checks = 0;

  nes_inv_pipe #(.DW(3), .STAGES(2)) u3 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we3), .cfg_mask(cfg_mask3), .mode(mode3),
    .in_vld(in_vld3), .in_rdy(in_rdy3), .in_dat(in_dat3),
    .out_vld(out_vld3), .out_rdy(out_rdy3), .out_dat(out_dat3), .beat_cnt(cnt3)
  );

  nes_inv_pipe #(.DW(8), .STAGES(2)) u8 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we8), .cfg_mask(cfg_mask8), .mode(mode8),
    .in_vld(in_vld8), .in_rdy(in_rdy8), .in_dat(in_dat8),
    .out_vld(out_vld8), .out_rdy(out_rdy8), .out_dat(out_dat8), .beat_cnt(cnt8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are settled afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp8 [4];
    logic [1:0] rdy_pat [4];
    int sent, rcvd, occ;
    logic [2:0] held;
    logic was_stalled;

    exp8    = '{8'h5A, 8'hA5, 8'h55, 8'h00};
    rdy_pat = '{2'd1, 2'd0, 2'd0, 2'd1};

    rst = 1'b1;
    cfg_we3 = 0; cfg_mask3 = 0; mode3 = 0; in_vld3 = 0; in_dat3 = 0; out_rdy3 = 1;
    cfg_we8 = 0; cfg_mask8 = 0; mode8 = 0; in_vld8 = 0; in_dat8 = 0; out_rdy8 = 1;
    #1;
    chk("rst_out_vld", {31'd0, out_vld3}, 32'd0);
    chk("rst_out_dat", {29'd0, out_dat3}, 32'd0);
    chk("rst_in_rdy", {31'd0, in_rdy3}, 32'd1);
    chk("rst_cnt", {16'd0, cnt3}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    chk("post_rst_in_rdy", {31'd0, in_rdy3}, 32'd1);

    // Mode 1 invert, latency STAGES cycles
    mode3 = 2'd1; in_dat3 = 3'b010; in_vld3 = 1;
    tick();
    in_vld3 = 0;
    chk("inv_lat_vld0", {31'd0, out_vld3}, 32'd0);
    tick();
    chk("inv_vld", {31'd0, out_vld3}, 32'd1);
    chk("inv_dat", {29'd0, out_dat3}, 32'd5);
    chk("inv_cnt0", {16'd0, cnt3}, 32'd0);
    tick();
    chk("inv_cnt1", {16'd0, cnt3}, 32'd1);
    chk("inv_drained", {31'd0, out_vld3}, 32'd0);

    // Mode 2 with reset mask, then a mask write colliding with a beat
    mode3 = 2'd2; in_dat3 = 3'b110; in_vld3 = 1;
    tick();
    cfg_we3 = 1; cfg_mask3 = 3'b100;
    tick();
    cfg_we3 = 0;
    chk("mask_b1", {29'd0, out_dat3}, 32'd1);
    tick();
    in_vld3 = 0;
    chk("mask_b2_old", {29'd0, out_dat3}, 32'd1);
    tick();
    chk("mask_b3_new", {29'd0, out_dat3}, 32'b010);
    chk("mask_b3_vld", {31'd0, out_vld3}, 32'd1);
    tick();
    chk("mask_cnt", {16'd0, cnt3}, 32'd4);

    // Stream 0..5 in mode 0 with out_rdy pattern 1,0,0,1
    mode3 = 2'd0; sent = 0; rcvd = 0; was_stalled = 0; held = 0;
    for (int cyc = 0; cyc < 60 && rcvd < 6; cyc++) begin
      out_rdy3 = rdy_pat[cyc % 4][0];
      in_vld3  = (sent < 6);
      in_dat3  = sent[2:0];
      @(negedge clk);
      occ = sent - rcvd;
      chk("strm_in_rdy", {31'd0, in_rdy3}, (occ == 2 && !out_rdy3) ? 32'd0 : 32'd1);
      if (was_stalled) chk("strm_hold", {29'd0, out_dat3}, {29'd0, held});
      if (out_vld3 && out_rdy3) begin
        chk("strm_order", {29'd0, out_dat3}, rcvd);
        rcvd++;
      end
      was_stalled = out_vld3 && !out_rdy3;
      held = out_dat3;
      if (in_vld3 && in_rdy3) sent++;
      @(posedge clk);
      #1;
    end
    in_vld3 = 0; out_rdy3 = 1;
    chk("strm_all_out", rcvd, 32'd6);
    tick();
    chk("strm_cnt", {16'd0, cnt3}, 32'd10);

    // DW=8 mixed modes with mask 0F
    cfg_we8 = 1; cfg_mask8 = 8'h0F;
    tick();
    cfg_we8 = 0; in_dat8 = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      mode8 = 2'(k); in_vld8 = 1;
      tick();
      if (k >= 1) chk("mix_dat", {24'd0, out_dat8}, {24'd0, exp8[k-1]});
    end
    in_vld8 = 0;
    tick();
    chk("mix_dat_mute", {24'd0, out_dat8}, {24'd0, exp8[3]});
    chk("mix_vld", {31'd0, out_vld8}, 32'd1);
    tick();
    chk("mix_cnt", {16'd0, cnt8}, 32'd4);

    // Fill with out_rdy=0, then reset mid-flight
    out_rdy8 = 0; mode8 = 2'd0; in_vld8 = 1; in_dat8 = 8'h11;
    tick();
    in_dat8 = 8'h22;
    tick();
    in_vld8 = 0;
    chk("full_vld", {31'd0, out_vld8}, 32'd1);
    chk("full_in_rdy", {31'd0, in_rdy8}, 32'd0);
    chk("full_dat", {24'd0, out_dat8}, 32'h11);
    out_rdy8 = 1;
    #1;
    chk("full_drain_rdy", {31'd0, in_rdy8}, 32'd1);
    out_rdy8 = 0;
    #1;
    rst = 1;
    #1;
    chk("arst_vld", {31'd0, out_vld8}, 32'd0);
    chk("arst_in_rdy", {31'd0, in_rdy8}, 32'd1);
    chk("arst_cnt8", {16'd0, cnt8}, 32'd0);
    chk("arst_cnt3", {16'd0, cnt3}, 32'd0);
    tick();
    rst = 0; out_rdy8 = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_stale", {31'd0, out_vld8}, 32'd0);
    end
    mode8 = 2'd2; in_dat8 = 8'h00; in_vld8 = 1;
    tick();
    in_vld8 = 0;
    tick();
    chk("mask_rst_ff", {24'd0, out_dat8}, 32'hFF);
    tick();
    chk("cnt8_after", {16'd0, cnt8}, 32'd1);

    // Counter wrap on DW=3 instance
    mode3 = 2'd0; in_dat3 = 3'd3; out_rdy3 = 1; in_vld3 = 1;
    for (int n = 0; n < 65535; n++) begin
      @(posedge clk);
    end
    #1;
    in_vld3 = 0;
    tick(); tick();
    chk("cnt_ffff", {16'd0, cnt3}, 32'hFFFF);
    chk("cnt_idle", {31'd0, out_vld3}, 32'd0);
    in_vld3 = 1;
    tick();
    in_vld3 = 0;
    tick();
    chk("wrap_pre", {16'd0, cnt3}, 32'hFFFF);
    tick();
    chk("wrap_zero", {16'd0, cnt3}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
